vote_tally_n: RTL
=================

// Module: vote_tally_n
// PURPOSE
//  Parametrised N-candidate electronic voting machine core: debounced one-vote-per-press
//  capture, saturating per-candidate tallies, result display and live winner/tie tracking.
//  Sits between the raw push-button pins and the LED/display driver.
//  Successor to the fixed 4-button machine; adds press qualification and multi-press rejection.
// PARAMETERS
//  NUM_CAND     4   number of candidates/buttons (2..16)
//  CNT_W        8   tally width per candidate; also led width
//  HOLD_CYCLES  10  consecutive cycles a single button must be held to register a vote (>=2)
//  IDX_W        $clog2(NUM_CAND) (localparam) candidate index width
// PORTS
//  clock      in   1          single clock, rising edge
//  reset      in   1          asynchronous, active-low; clears all state
//  mode       in   1          0 = voting, 1 = result display
//  clear      in   1          synchronous tally clear, honoured only when mode=1
//  button     in   NUM_CAND   raw candidate buttons, bit i = candidate i (already synchronised)
//  led        out  CNT_W      mode 1: tally of selected candidate; mode 0: 0
//  vote_valid out  1          one-cycle pulse when a vote is committed
//  vote_idx   out  IDX_W      index of last committed vote (valid with vote_valid, held after)
//  winner     out  IDX_W      index of highest tally, lowest index on equal tallies
//  tie        out  1          1 when >=2 candidates share the max tally and max > 0
// BEHAVIOUR
//  Reset (reset=0): all tallies 0, FSM IDLE, led=0, vote_valid=0, vote_idx=0, winner=0, tie=0.
//  Vote FSM (active only while mode=0):
//   IDLE:    button==0 stay; exactly one bit set -> ARM, hold_cnt=1, cand latched;
//            >1 bit set -> REJECT.
//   ARM:     same single bit still set -> hold_cnt++; hold_cnt reaches HOLD_CYCLES -> COMMIT.
//            button==0 before HOLD_CYCLES -> IDLE (no vote, glitch filtered).
//            any other pattern (extra/different bit) -> REJECT (no vote).
//   COMMIT:  1 cycle; tally[cand] += 1 saturating at 2^CNT_W-1; vote_valid=1,
//            vote_idx=cand; -> RELEASE.
//   RELEASE: wait for button==0 -> IDLE. Holding a button never yields a second vote.
//   REJECT:  wait for button==0 -> IDLE; no tally change.
//  mode=1 at any cycle: FSM forced to RELEASE (aborts ARM, no vote); COMMIT already entered
//   completes that cycle. Return to mode=0 requires all buttons released before a new vote.
//  Vote latency: commit occurs HOLD_CYCLES+1 rising edges after button first sampled high;
//   vote_valid is registered.
//  Display (mode=1): led registered, 1-cycle latency: tally of lowest-index asserted button,
//   0 if button==0. In mode=0 led=0 (registered).
//  clear (mode=1 and clear=1): all tallies 0 next edge; winner/tie follow one cycle later.
//   clear ignored in mode=0.
//  Saturation: tally at max stays at max; vote_valid still pulses.
//  winner/tie: registered, recomputed from tallies every cycle; 1-cycle lag behind tallies.
//   All-zero tallies -> winner=0, tie=0.
//  Reset mid-vote: immediate return to reset state; no partial count retained.
// TESTING (NUM_CAND=4, CNT_W=8, HOLD_CYCLES=10, 10 ns clock)
//  1 Reset release, button=4'b0001 held 20 cycles then 0 -> one vote_valid, vote_idx=0;
//    mode=1, button=4'b0001 -> led=1; winner=0, tie=0.
//  2 button=4'b0010 held 5 cycles then released -> no vote_valid; tally1 stays 0.
//  3 button=4'b0011 held 30 cycles -> no vote; button=4'b0001 held 12, then 4'b0011 before
//    release -> exactly one vote for candidate 0 (extra press in RELEASE ignored).
//  4 One vote each for cand 0 and 2 -> winner=0, tie=1; add vote cand 2 -> winner=2, tie=0.
//  5 300 votes to cand 3 -> tally3=255 (saturated), vote_valid pulsed 300 times;
//    mode=1, button=4'b1000 -> led=255.
//  6 Assert mode=1 at ARM cycle 6 -> no vote; clear=1 in mode=1 -> all led reads 0,
//    winner=0, tie=0; drive reset=0 during ARM -> all outputs 0 immediately.

Source files
------------

// File: rtl/vote_tally_n.sv
// N-candidate voting core: debounced single-press capture, saturating tallies, display, winner/tie.
// Latency: vote commits HOLD_CYCLES+1 edges after first press sample; led/winner/tie registered (1 cycle).
// Backpressure: none; buttons are sampled every cycle and held presses never produce extra votes.
module vote_tally_n #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mode,
    input  logic                        clear,
    input  logic [NUM_CAND-1:0]         button,
    output logic [CNT_W-1:0]            led,
    output logic                        vote_valid,
    output logic [$clog2(NUM_CAND)-1:0] vote_idx,
    output logic [$clog2(NUM_CAND)-1:0] winner,
    output logic                        tie
);
    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        COMMIT  = 3'd2,
        RELEASE = 3'd3,
        REJECT  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]  tally_q [NUM_CAND];
    logic [CNT_W-1:0]  tally_d [NUM_CAND];
    logic [CNT_W-1:0]  led_q, led_d;
    logic              vote_valid_q, vote_valid_d;
    logic [IDX_W-1:0]  vote_idx_q, vote_idx_d;
    logic [IDX_W-1:0]  winner_q, winner_d;
    logic              tie_q, tie_d;

    logic              commit;
    logic              onehot;
    logic [IDX_W-1:0]  low_idx;
    logic [NUM_CAND-1:0] cand_mask;
    logic [CNT_W-1:0]  max_v;
    logic              dup;

    // Lowest asserted button serves both vote capture and display select.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (button[i]) low_idx = IDX_W'(i);
        end
        onehot    = (button != '0) && ((button & (button - NUM_CAND'(1))) == '0);
        cand_mask = NUM_CAND'(1) << cand_q;
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cand_d     = cand_q;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (onehot) begin
                    state_d    = ARM;
                    hold_cnt_d = HC_W'(1);
                    cand_d     = low_idx;
                end else if (button != '0) begin
                    state_d = REJECT;
                end
            end
            ARM: begin
                if (button == cand_mask) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                    if (hold_cnt_q >= HC_W'(HOLD_CYCLES - 1)) state_d = COMMIT;
                end else if (button == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = REJECT;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = RELEASE;
            end
            RELEASE, REJECT: begin
                if (button == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Display mode parks the FSM so a vote can only start from a fresh press.
        if (mode && state_q != COMMIT) state_d = RELEASE;
    end

    always_comb begin
        for (int i = 0; i < NUM_CAND; i++) begin
            tally_d[i] = tally_q[i];
            if (commit && cand_q == IDX_W'(i) && tally_q[i] != '1)
                tally_d[i] = tally_q[i] + CNT_W'(1);
            if (mode && clear) tally_d[i] = '0;
        end
        vote_valid_d = commit;
        vote_idx_d   = commit ? cand_q : vote_idx_q;
        led_d        = (mode && button != '0) ? tally_q[low_idx] : '0;
    end

    // Strict '>' keeps the lowest index on equal tallies.
    always_comb begin
        max_v    = tally_q[0];
        winner_d = '0;
        dup      = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally_q[i] > max_v) begin
                max_v    = tally_q[i];
                winner_d = IDX_W'(i);
                dup      = 1'b0;
            end else if (tally_q[i] == max_v) begin
                dup = 1'b1;
            end
        end
        tie_d = dup && (max_v != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            cand_q       <= '0;
            led_q        <= '0;
            vote_valid_q <= 1'b0;
            vote_idx_q   <= '0;
            winner_q     <= '0;
            tie_q        <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cand_q       <= cand_d;
            led_q        <= led_d;
            vote_valid_q <= vote_valid_d;
            vote_idx_q   <= vote_idx_d;
            winner_q     <= winner_d;
            tie_q        <= tie_d;
            for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= tally_d[i];
        end
    end

    assign led        = led_q;
    assign vote_valid = vote_valid_q;
    assign vote_idx   = vote_idx_q;
    assign winner     = winner_q;
    assign tie        = tie_q;
endmodule
